fetch_stage: RTL and testbench
==============================

# fetch_stage

Multi-cycle instruction fetch stage that owns the architectural fetch PC, issues one instruction-memory read at a time over a valid/ready request/response interface, and hands each fetched instruction to decode over a valid/ready handshake. It sits directly upstream of the decoder and replaces the combinational PC-indexed instruction read. Execute-stage jump targets (jal/jalr) arrive as a one-cycle redirect, which squashes any in-flight or held fetch.

## Interface
- PC_WIDTH, 32, fetch address width
- RESET_PC, 32'h80000000, first fetch address after reset
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- redirect_valid_i  in  1  one-cycle pulse: restart fetch at redirect_pc_i
- redirect_pc_i  in  PC_WIDTH  redirect target
- imem_req_valid_o  out  1  read request valid
- imem_req_addr_o  out  PC_WIDTH  read address, word aligned
- imem_req_ready_i  in  1  memory accepts request
- imem_rsp_valid_i  in  1  read data valid (always accepted)
- imem_rsp_data_i  in  32  instruction word
- imem_rsp_err_i  in  1  access fault on this response
- inst_valid_o  out  1  instruction available to decode
- inst_o  out  32  instruction word
- inst_pc_o  out  PC_WIDTH  address of inst_o
- inst_fault_o  out  1  fetch fault (bus error or misaligned PC)
- inst_ready_i  in  1  decode accepts instruction

## Operation
- State machine REQ, WAIT, HOLD. Registers: pc_r (next fetch PC), req_addr_r, kill_r, inst/pc/fault holding registers.
- Reset (rst_i=1 at an edge): state=REQ, pc_r=req_addr_r=RESET_PC, kill_r=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, inst_fault_o=0. imem_req_valid_o is 1 in REQ, so a request for RESET_PC is visible in the first cycle after reset. Reset mid-transaction drops everything; a late response is ignored in REQ.
- REQ: imem_req_valid_o=1, imem_req_addr_o=req_addr_r, held stable until imem_req_ready_i. On handshake -> WAIT. If pc_r[1:0]!=0, no request is issued: go to HOLD with inst_fault_o=1, inst_o=0, inst_pc_o=pc_r.
- WAIT: on imem_rsp_valid_i: if kill_r, discard, clear kill_r, req_addr_r<=pc_r, -> REQ; else capture inst_o=rsp_data (0 when err), inst_fault_o=rsp_err, inst_pc_o=req_addr_r, -> HOLD.
- HOLD: inst_valid_o=1; outputs stable until inst_valid_o & inst_ready_i. On accept: pc_r<=pc_r+4 (mod 2^PC_WIDTH, wraps), req_addr_r<=pc_r+4, -> REQ.
- Redirect (highest priority, any state): pc_r<=redirect_pc_i. REQ without handshake this cycle: request stays asserted with old address (stability rule), kill_r<=1, goes WAIT and discards on return. REQ with handshake: kill_r<=1, -> WAIT. WAIT: kill_r<=1 unless rsp_valid same cycle, in which case response is discarded and -> REQ at redirect target. HOLD: held instruction dropped (even if inst_ready_i same cycle; decode must treat a redirect-cycle accept as squashed), -> REQ with req_addr_r<=redirect_pc_i.
- imem_rsp_valid_i outside WAIT is ignored. A fault does not stop fetch; PC advances on accept as normal.

## Timing
- Zero-latency memory (ready=1, response one cycle after handshake): request cycle N, response N+1, inst_valid_o N+2, accept N+2, next request N+3 -> one instruction per 3 cycles.
- inst_valid_o, inst_o, inst_pc_o, inst_fault_o are registered; no combinational path from any input to any output except none (imem_req_valid_o decodes state only).
- Redirect to first request at target: 1 cycle from HOLD; after outstanding response when in WAIT.
- At most one outstanding request.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetch_cnt_o (32, increments per decode accept, excluding squashed) and perf_stall_cnt_o (32, increments each cycle in REQ or WAIT); both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; fetch behaviour identical.

## Test plan
- Reset release, ready=1, 1-cycle memory returning 0x00000013: requests at 0x80000000, 0x80000004, 0x80000008; inst_valid_o every 3rd cycle, inst_pc_o matching.
- Memory ready low 4 cycles: imem_req_addr_o stays 0x80000000 and valid stays 1 throughout; one request only.
- Redirect to 0x80000100 while in WAIT: pending response discarded (no inst_valid_o), next request 0x80000100.
- Redirect to 0x80000200 in HOLD with inst_ready_i=0: held instruction dropped, request 0x80000200 next cycle.
- Redirect to 0x80000102: no memory request; inst_valid_o=1, inst_fault_o=1, inst_o=0, inst_pc_o=0x80000102.
- rsp_err=1 on 0x80000004: inst_fault_o=1, inst_o=0; after accept fetch continues at 0x80000008; with FETCH_PERF_EN perf_fetch_cnt_o counts it.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Multi-cycle instruction fetch with one outstanding imem read and
//            a valid/ready hand-off to decode. `FETCH_PERF_EN adds counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 'h80000000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                redirect_valid_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                imem_req_valid_o,
  output logic [PC_WIDTH-1:0] imem_req_addr_o,
  input  logic                imem_req_ready_i,
  input  logic                imem_rsp_valid_i,
  input  logic [31:0]         imem_rsp_data_i,
  input  logic                imem_rsp_err_i,
  output logic                inst_valid_o,
  output logic [31:0]         inst_o,
  output logic [PC_WIDTH-1:0] inst_pc_o,
  output logic                inst_fault_o,
  input  logic                inst_ready_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt_o,
  output logic [31:0]         perf_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_req_addr;
  logic                r_kill;
  logic                r_inst_valid;
  logic [31:0]         r_inst;
  logic [PC_WIDTH-1:0] r_inst_pc;
  logic                r_inst_fault;

  logic                w_misaligned;
  logic                w_req_issue;
  logic                w_req_hs;
  logic [PC_WIDTH-1:0] w_pc_next;

  // While a killed request is still pending, the new PC is not checked yet.
  assign w_misaligned = |r_pc[1:0];
  assign w_req_issue  = (r_state == S_REQ) && !(w_misaligned && !r_kill);
  assign w_req_hs     = w_req_issue && imem_req_ready_i;
  assign w_pc_next    = r_pc + PC_WIDTH'(4);

  assign imem_req_valid_o = w_req_issue;
  assign imem_req_addr_o  = r_req_addr;
  assign inst_valid_o     = r_inst_valid;
  assign inst_o           = r_inst;
  assign inst_pc_o        = r_inst_pc;
  assign inst_fault_o     = r_inst_fault;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_kill       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_fault <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (!w_req_issue) begin
            if (redirect_valid_i) begin
              r_pc       <= redirect_pc_i;
              r_req_addr <= redirect_pc_i;
            end else begin
              r_inst_valid <= 1'b1;
              r_inst       <= '0;
              r_inst_pc    <= r_pc;
              r_inst_fault <= 1'b1;
              r_state      <= S_HOLD;
            end
          end else begin
            if (w_req_hs) r_state <= S_WAIT;
            // The visible request must stay stable, so it is completed then dropped.
            if (redirect_valid_i) begin
              r_pc   <= redirect_pc_i;
              r_kill <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (redirect_valid_i) begin
            r_pc <= redirect_pc_i;
            if (imem_rsp_valid_i) begin
              r_kill     <= 1'b0;
              r_req_addr <= redirect_pc_i;
              r_state    <= S_REQ;
            end else begin
              r_kill <= 1'b1;
            end
          end else if (imem_rsp_valid_i) begin
            if (r_kill) begin
              r_kill     <= 1'b0;
              r_req_addr <= r_pc;
              r_state    <= S_REQ;
            end else begin
              r_inst_valid <= 1'b1;
              r_inst       <= imem_rsp_err_i ? 32'h0 : imem_rsp_data_i;
              r_inst_pc    <= r_req_addr;
              r_inst_fault <= imem_rsp_err_i;
              r_state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid_i) begin
            r_pc         <= redirect_pc_i;
            r_req_addr   <= redirect_pc_i;
            r_inst_valid <= 1'b0;
            r_state      <= S_REQ;
          end else if (inst_ready_i) begin
            r_pc         <= w_pc_next;
            r_req_addr   <= w_pc_next;
            r_inst_valid <= 1'b0;
            r_state      <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (r_state == S_HOLD && inst_ready_i && !redirect_valid_i)
        r_perf_fetch <= r_perf_fetch + 32'd1;
      if (r_state == S_REQ || r_state == S_WAIT)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = r_perf_fetch;
  assign perf_stall_cnt_o = r_perf_stall;
`else
  // Counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Cycle-by-cycle directed vectors plus a streaming sequence for
//            fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] B    = 32'h80000000;
  localparam logic [31:0] I13  = 32'h00000013;
  localparam logic [31:0] I93  = 32'h00000093;
  localparam logic [31:0] I113 = 32'h00000113;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h80000000)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_addr_o  (imem_req_addr),
    .imem_req_ready_i (imem_req_ready),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .imem_rsp_err_i   (imem_rsp_err),
    .inst_valid_o     (inst_valid),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc),
    .inst_fault_o     (inst_fault),
    .inst_ready_i     (inst_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt),
    .perf_stall_cnt_o (perf_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [31:0] rpc;
    logic        rdy;
    logic        rspv;
    logic [31:0] data;
    logic        err;
    logic        irdy;
    logic        chk;
    logic        erv;
    logic [31:0] eaddr;
    logic        eiv;
    logic [31:0] einst;
    logic [31:0] epc;
    logic        ef;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic rd, input logic [31:0] rp,
                     input logic rdy, input logic rv, input logic [31:0] d,
                     input logic e, input logic ir, input logic c,
                     input logic erv, input logic [31:0] ea, input logic eiv,
                     input logic [31:0] ei, input logic [31:0] ep, input logic ef);
    vec_t t;
    t.rst = r; t.rdv = rd; t.rpc = rp; t.rdy = rdy; t.rspv = rv; t.data = d;
    t.err = e; t.irdy = ir; t.chk = c; t.erv = erv; t.eaddr = ea; t.eiv = eiv;
    t.einst = ei; t.epc = ep; t.ef = ef;
    tbl.push_back(t);
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    logic [98:0] act;
    logic [98:0] exp;
    int          k;
    logic        hs;

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0; inst_ready = 1'b0;

    //   rst rdv rpc            rdy rspv data          err irdy chk erv eaddr          eiv einst epc            ef
    add(1, 0, 0,              0, 0, 0,             0, 0,   0, 0, 0,             0, 0,    0,             0);
    add(1, 0, 0,              0, 0, 0,             0, 0,   1, 1, B,             0, 0,    0,             0);
    add(0, 0, 0,              1, 0, 0,             0, 0,   1, 1, B,             0, 0,    0,             0);
    add(0, 0, 0,              1, 1, I13,           0, 1,   1, 0, B,             0, 0,    0,             0);
    add(0, 0, 0,              1, 0, 0,             0, 1,   1, 0, B,             1, I13,  B,             0);
    add(0, 0, 0,              1, 0, 0,             0, 0,   1, 1, B+4,           0, I13,  B,             0);
    add(0, 0, 0,              1, 1, I13,           0, 0,   1, 0, B+4,           0, I13,  B,             0);
    add(0, 0, 0,              1, 0, 0,             0, 1,   1, 0, B+4,           1, I13,  B+4,           0);
    add(0, 0, 0,              0, 0, 0,             0, 0,   1, 1, B+8,           0, I13,  B+4,           0);
    add(1, 0, 0,              0, 0, 0,             0, 0,   1, 1, B+8,           0, I13,  B+4,           0);
    // memory not ready for four cycles: request held stable
    for (int i = 0; i < 4; i++)
      add(0, 0, 0,            0, 0, 0,             0, 0,   1, 1, B,             0, 0,    0,             0);
    add(0, 0, 0,              1, 0, 0,             0, 0,   1, 1, B,             0, 0,    0,             0);
    // redirect in WAIT, response arrives a cycle later and is discarded
    add(0, 1, B+32'h100,      0, 0, 0,             0, 0,   1, 0, B,             0, 0,    0,             0);
    add(0, 0, 0,              0, 1, 32'hdeadbeef,  0, 1,   1, 0, B,             0, 0,    0,             0);
    add(0, 0, 0,              1, 0, 0,             0, 0,   1, 1, B+32'h100,     0, 0,    0,             0);
    add(0, 0, 0,              1, 1, I93,           0, 0,   1, 0, B+32'h100,     0, 0,    0,             0);
    // redirect in HOLD with decode stalled
    add(0, 1, B+32'h200,      0, 0, 0,             0, 0,   1, 0, B+32'h100,     1, I93,  B+32'h100,     0);
    add(0, 0, 0,              1, 0, 0,             0, 0,   1, 1, B+32'h200,     0, I93,  B+32'h100,     0);
    add(0, 0, 0,              0, 1, I13,           0, 0,   1, 0, B+32'h200,     0, I93,  B+32'h100,     0);
    // redirect to misaligned target, coincident accept is squashed
    add(0, 1, B+32'h102,      0, 0, 0,             0, 1,   1, 0, B+32'h200,     1, I13,  B+32'h200,     0);
    add(0, 0, 0,              1, 0, 0,             0, 0,   1, 0, B+32'h102,     0, I13,  B+32'h200,     0);
    add(0, 0, 0,              1, 0, 0,             0, 0,   1, 0, B+32'h102,     1, 0,    B+32'h102,     1);
    add(0, 1, B+4,            0, 0, 0,             0, 0,   1, 0, B+32'h102,     1, 0,    B+32'h102,     1);
    // bus error on 0x80000004, fetch continues at 0x80000008
    add(0, 0, 0,              1, 0, 0,             0, 0,   1, 1, B+4,           0, 0,    B+32'h102,     1);
    add(0, 0, 0,              0, 1, 32'h12345678,  1, 0,   1, 0, B+4,           0, 0,    B+32'h102,     1);
    add(0, 0, 0,              0, 0, 0,             0, 1,   1, 0, B+4,           1, 0,    B+4,           1);
    add(0, 0, 0,              0, 0, 0,             0, 0,   1, 1, B+8,           0, 0,    B+4,           1);
    // redirect in REQ without handshake: old request stays, then discarded
    add(0, 1, B+32'h300,      0, 0, 0,             0, 0,   1, 1, B+8,           0, 0,    B+4,           1);
    add(0, 0, 0,              1, 0, 0,             0, 0,   1, 1, B+8,           0, 0,    B+4,           1);
    add(0, 0, 0,              0, 1, I13,           0, 0,   1, 0, B+8,           0, 0,    B+4,           1);
    add(0, 0, 0,              0, 0, 0,             0, 0,   1, 1, B+32'h300,     0, 0,    B+4,           1);
    // redirect with handshake to top of address space, then wrap to zero
    add(0, 1, 32'hfffffffc,   1, 0, 0,             0, 0,   1, 1, B+32'h300,     0, 0,    B+4,           1);
    add(0, 0, 0,              0, 1, I13,           0, 0,   1, 0, B+32'h300,     0, 0,    B+4,           1);
    add(0, 0, 0,              1, 0, 0,             0, 0,   1, 1, 32'hfffffffc,  0, 0,    B+4,           1);
    add(0, 0, 0,              0, 1, I113,          0, 0,   1, 0, 32'hfffffffc,  0, 0,    B+4,           1);
    add(0, 0, 0,              0, 0, 0,             0, 1,   1, 0, 32'hfffffffc,  1, I113, 32'hfffffffc,  0);
    add(0, 0, 0,              0, 0, 0,             0, 0,   1, 1, 32'h0,         0, I113, 32'hfffffffc,  0);
    // reset mid-transaction, late response ignored
    add(0, 0, 0,              1, 0, 0,             0, 0,   1, 1, 32'h0,         0, I113, 32'hfffffffc,  0);
    add(1, 0, 0,              0, 0, 0,             0, 0,   1, 0, 32'h0,         0, I113, 32'hfffffffc,  0);
    add(0, 0, 0,              0, 1, 32'h55,        0, 0,   1, 1, B,             0, 0,    0,             0);
    add(0, 0, 0,              0, 0, 0,             0, 0,   1, 1, B,             0, 0,    0,             0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; redirect_valid = tbl[i].rdv; redirect_pc = tbl[i].rpc;
      imem_req_ready = tbl[i].rdy; imem_rsp_valid = tbl[i].rspv;
      imem_rsp_data = tbl[i].data; imem_rsp_err = tbl[i].err; inst_ready = tbl[i].irdy;
      #1;
      if (tbl[i].chk) begin
        act = {imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault};
        exp = {tbl[i].erv, tbl[i].eaddr, tbl[i].eiv, tbl[i].einst, tbl[i].epc, tbl[i].ef};
        n_chk++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL vec%0d: got rv=%b a=%h iv=%b i=%h pc=%h f=%b expected rv=%b a=%h iv=%b i=%h pc=%h f=%b",
                   i, act[98], act[97:66], act[65], act[64:33], act[32:1], act[0],
                   exp[98], exp[97:66], exp[65], exp[64:33], exp[32:1], exp[0]);
        end
      end
    end

    // Streaming with a one-cycle memory: one instruction every third cycle
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    imem_req_ready = 1'b1; inst_ready = 1'b1; imem_rsp_data = I13;
    @(negedge clk);
    rst = 1'b0;
    hs = 1'b0;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      imem_rsp_valid = hs;
      #1;
`ifdef FETCH_PERF_EN
      if (c == 0) begin
        check32("perf_fetch_reset", perf_fetch_cnt, 32'd0);
        check32("perf_stall_reset", perf_stall_cnt, 32'd0);
      end
`endif
      if (inst_valid) begin
        check32("stream_pc", inst_pc, B + 32'(4 * k));
        check32("stream_cycle", 32'(c), 32'(3 * k + 2));
        k++;
      end
      hs = imem_req_valid;
    end
    @(negedge clk);
    imem_rsp_valid = hs;
    #1;
    check32("stream_count", 32'(k), 32'd10);
    check32("stream_next_addr", imem_req_addr, B + 32'd40);
`ifdef FETCH_PERF_EN
    check32("perf_fetch", perf_fetch_cnt, 32'd10);
    check32("perf_stall", perf_stall_cnt, 32'd20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
